// File: rtl/debounce_pulse_if.sv
// debounce_pulse_if: groups the raw button input with the debounced level and
// edge pulses. The slave modport is the debouncer; the master modport is
// whatever drives the raw input and consumes the clean outputs.
interface debounce_pulse_if;
    logic btn_in;
    logic level_out;
    logic rise_pulse;
    logic fall_pulse;

    modport master (
        output btn_in,
        input  level_out,
        input  rise_pulse,
        input  fall_pulse
    );

    modport slave (
        input  btn_in,
        output level_out,
        output rise_pulse,
        output fall_pulse
    );
endinterface

// File: rtl/debounce_pulse.sv
// debounce_pulse: two-flop synchroniser followed by a four-state debounce FSM.
// A new input value must hold for STABLE_CYCLES consecutive synchronised
// cycles before level_out follows it; each accepted edge produces a one-cycle
// registered pulse. All outputs come straight from flops.
//
// Optional feature macro: DEBOUNCE_FALL_PULSE_EN
//   defined   -> fall_pulse fires for one cycle when level_out goes 1->0
//   undefined -> fall_pulse is tied to 0 (level_out timing is unchanged)
module debounce_pulse #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 5
) (
    input  logic             clk,
    input  logic             reset,
    debounce_pulse_if.slave  bus
);

    // Reject configurations where the counter cannot reach STABLE_CYCLES-1.
    generate
        if (STABLE_CYCLES < 1 || STABLE_CYCLES > (1 << CNT_W)) begin : g_cfg_check
            $error("debounce_pulse: STABLE_CYCLES must be in 1..2**CNT_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    // Terminal count: the sample that completes the stable run.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_reg;
    logic             s2_reg;
    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             level_reg;
    logic             level_next;
    logic             rise_reg;
    logic             rise_next;
`ifdef DEBOUNCE_FALL_PULSE_EN
    logic             fall_reg;
    logic             fall_next;
`endif

    // Two-flop synchroniser; only s2_reg is seen by the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= bus.btn_in;
            s2_reg <= s1_reg;
        end
    end

    // FSM, stability counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE_LOW;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
            fall_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            rise_reg  <= rise_next;
`ifdef DEBOUNCE_FALL_PULSE_EN
            fall_reg  <= fall_next;
`endif
        end
    end

    // Next-state logic: an opposite sample in a WAIT state aborts back to the
    // prior IDLE state with no level change; pulses default low so they only
    // last one cycle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        level_next = level_reg;
        rise_next  = 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
        fall_next  = 1'b0;
`endif
        unique case (state_reg)
            IDLE_LOW: begin
                if (s2_reg) begin
                    state_next = WAIT_HIGH;
                    cnt_next   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s2_reg) begin
                    state_next = IDLE_LOW;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE_HIGH;
                    level_next = 1'b1;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!s2_reg) begin
                    state_next = WAIT_LOW;
                    cnt_next   = '0;
                end
            end
            WAIT_LOW: begin
                if (s2_reg) begin
                    state_next = IDLE_HIGH;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE_LOW;
                    level_next = 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
                    fall_next  = 1'b1;
`endif
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE_LOW;
            end
        endcase
    end

    assign bus.level_out  = level_reg;
    assign bus.rise_pulse = rise_reg;
`ifdef DEBOUNCE_FALL_PULSE_EN
    assign bus.fall_pulse = fall_reg;
`else
    assign bus.fall_pulse = 1'b0;
`endif

endmodule

// File: doc/debounce_pulse.md
# debounce_pulse

Debounces and synchronises a raw asynchronous input (push-button or switch) and produces a clean level plus single-cycle edge pulses. Sits directly upstream of the D flip-flop stages: `level_out` drives a flop's data input, and `rise_pulse` or `fall_pulse` drives its clear or enable. This keeps bounce and metastability out of the storage stage.

## Interface
- `STABLE_CYCLES`, default 16: consecutive synchronised cycles the new value must hold before it is accepted; legal range 1..2^CNT_W.
- `CNT_W`, default 5: width of the stability counter.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `btn_in`  input  1  raw asynchronous input; may bounce or glitch.
- `level_out`  output  1  debounced, registered level.
- `rise_pulse`  output  1  one-cycle pulse when `level_out` goes 0->1.
- `fall_pulse`  output  1  one-cycle pulse when `level_out` goes 1->0 (see Configuration).

## Operation
- **Synchroniser:** two-flop chain `btn_in` -> `s1` -> `s2`. Only `s2` feeds the FSM.
- **FSM states:**
  - `IDLE_LOW`: `s2`=1 -> `WAIT_HIGH`, cnt<=0.
  - `WAIT_HIGH`: `s2`=0 -> `IDLE_LOW`; else if cnt==STABLE_CYCLES-1 -> `IDLE_HIGH` with `level_out`<=1 and `rise_pulse`<=1; else cnt<=cnt+1.
  - `IDLE_HIGH`: `s2`=0 -> `WAIT_LOW`, cnt<=0.
  - `WAIT_LOW`: `s2`=1 -> `IDLE_HIGH`; else if cnt==STABLE_CYCLES-1 -> `IDLE_LOW` with `level_out`<=0 and `fall_pulse`<=1; else cnt<=cnt+1.
- **Pulses:** `rise_pulse` and `fall_pulse` are registered and deasserted on the cycle after assertion. Both are never high in the same cycle.
- **Counter:**
  - cnt is unsigned, CNT_W bits.
  - cnt never increments past STABLE_CYCLES-1, so it cannot wrap.
  - cnt is don't-care in the IDLE states and is held there.
- **Bounce during a WAIT state:** any opposite sample returns the FSM to the prior IDLE state. `level_out` is unchanged and no pulse is produced.
- **Reset, at any point including mid-WAIT:**
  - `s1`, `s2`, cnt <= 0; state <= `IDLE_LOW`.
  - `level_out`, `rise_pulse`, `fall_pulse` <= 0.
  - A pulse that would have fired on the reset edge is suppressed.
- **Reset release with `btn_in` held high:** behaves as a fresh press; a `rise_pulse` follows after the full latency.
- **Assertion:** STABLE_CYCLES > 2^CNT_W is illegal. The simulation assertion fires at time 0.

## Timing
- If `btn_in` is first sampled high at edge n and stays high:
  - `s2`=1 after edge n+1.
  - `WAIT_HIGH` entered at edge n+2.
  - `level_out` rises and `rise_pulse` asserts at edge n+STABLE_CYCLES+2.
  - `rise_pulse` deasserts at edge n+STABLE_CYCLES+3.
- Release is symmetric with identical latency.
- Minimum accepted stable width at `btn_in` is STABLE_CYCLES+1 cycles. Any shorter high or low run is rejected.
- Outputs are purely registered; there is no combinational path from `btn_in` to any output.

## Configuration
- **Macro `DEBOUNCE_FALL_PULSE_EN`**
- **Defined:** `fall_pulse` is generated as described in Operation.
- **Undefined:**
  - `fall_pulse` is tied to constant 0.
  - The `WAIT_LOW` -> `IDLE_LOW` transition still updates `level_out` with the same timing.
  - The port remains present, so the module outline is unchanged.

## Test plan
All scenarios use STABLE_CYCLES=4 and CNT_W=3.
- **Clean press:** `btn_in` 0->1 sampled at edge 10, held -> `level_out`=1 and `rise_pulse`=1 at edge 16; `rise_pulse`=0 at edge 17; `fall_pulse` stays 0.
- **Glitch:** `btn_in` high for 4 cycles starting edge 10, then low -> `level_out` stays 0; no pulse at any point.
- **Bounce then settle:** pattern 1,0,1,1,0 from edge 10, then constant 1 from edge 15 -> single `rise_pulse` at edge 21; exactly one pulse in total.
- **Release with macro defined:** from the settled-high state, `btn_in`->0 at edge 40 -> `level_out`=0 and `fall_pulse`=1 at edge 46, one cycle only. Without the macro: same `level_out` timing, `fall_pulse` always 0.
- **Reset mid-WAIT:** `btn_in` high from edge 10, `reset`=1 at edge 14 for one cycle -> all outputs 0 at edge 14; `rise_pulse` at edge 21, counted from the edge-15 sample.
- **Reset while high:** with `level_out`=1, assert `reset` -> `level_out`=0 and no `fall_pulse`. With `btn_in` held high, `rise_pulse` fires 6 edges after reset release.
